tcu_tile_engine: RTL and testbench

Sequential tile multiply engine that sits directly downstream of the tensor-core dispatch/CSR sequencer in the core's TCU path. It accepts one A/B element pair per cycle during a load phase, computes C = A × B for a TILE_N × TILE_N tile with one multiply-accumulate per cycle, and streams C back one element per cycle on request. Results are returned to the sequencer for CSR write-back.

---
 rtl/tcu_tile_engine.sv | 195 +++++++++++++++++++
 tb/tb_tcu_tile_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_tile_engine.sv
// Sequential TILE_N x TILE_N tile multiplier for the TCU path.
// Loads A/B one pair per cycle, runs one MAC per cycle, streams C.
module tcu_tile_engine #(
    parameter int TILE_N = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in_a,
    input  logic [DATA_W-1:0] data_in_b,
    output logic              load_done,
    output logic              execute_done,
    input  logic              store_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out_c,
    output logic              store_done,
    output logic              busy
);

    localparam int NN = TILE_N * TILE_N;
    localparam int IW = $clog2(NN);
    localparam int KW = $clog2(TILE_N);
    localparam logic [IW-1:0] IMAX = IW'(NN - 1);
    localparam logic [KW-1:0] KMAX = KW'(TILE_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WAIT,
        S_STORE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [KW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ld_done_q, ld_done_d;
    logic              ex_done_q, ex_done_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              sd_q, sd_d;

    logic [DATA_W-1:0] a_q [NN];
    logic [DATA_W-1:0] b_q [NN];
    logic [DATA_W-1:0] c_q [NN];

    logic              ab_we;
    logic              c_we;
    logic              do_beat;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] mac;

    // Row-major addressing: {row, col} is the flat index since N is 2^k.
    assign prod = a_q[{i_q, k_q}] * b_q[{k_q, j_q}];
    assign mac  = acc_q + prod;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        ld_done_d = 1'b0;
        ex_done_d = 1'b0;
        ov_d      = 1'b0;
        dout_d    = '0;
        sd_d      = 1'b0;
        ab_we     = 1'b0;
        c_we      = 1'b0;
        do_beat   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ab_we = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IMAX) begin
                        state_d   = S_EXEC;
                        idx_d     = '0;
                        i_d       = '0;
                        j_d       = '0;
                        k_d       = '0;
                        acc_d     = '0;
                        ld_done_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (k_q == KMAX) begin
                    c_we  = 1'b1;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == KMAX) begin
                        j_d = '0;
                        if (i_q == KMAX) begin
                            i_d       = '0;
                            state_d   = S_WAIT;
                            ex_done_d = 1'b1;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = mac;
                    k_d   = k_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (store_start) begin
                    state_d = S_STORE;
                    do_beat = 1'b1;
                end
            end
            S_STORE: begin
                if (sd_q) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    do_beat = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_beat) begin
            ov_d   = 1'b1;
            dout_d = c_q[idx_q];
            sd_d   = (idx_q == IMAX);
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            ld_done_q <= 1'b0;
            ex_done_q <= 1'b0;
            ov_q      <= 1'b0;
            dout_q    <= '0;
            sd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            ld_done_q <= ld_done_d;
            ex_done_q <= ex_done_d;
            ov_q      <= ov_d;
            dout_q    <= dout_d;
            sd_q      <= sd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && ab_we) begin
            a_q[idx_q] <= data_in_a;
            b_q[idx_q] <= data_in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < NN; n++) begin
                c_q[n] <= '0;
            end
        end else if (c_we) begin
            c_q[{i_q, j_q}] <= mac;
        end
    end

    assign load_done    = ld_done_q;
    assign execute_done = ex_done_q;
    assign out_valid    = ov_q;
    assign data_out_c   = dout_q;
    assign store_done   = sd_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_tcu_tile_engine.sv
// Directed bench for tcu_tile_engine (TILE_N=2, DATA_W=32).
module tb_tcu_tile_engine;

    typedef logic [31:0] tile_t [4];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] data_in_a = '0;
    logic [31:0] data_in_b = '0;
    logic        load_done;
    logic        execute_done;
    logic        store_start = 1'b0;
    logic        out_valid;
    logic [31:0] data_out_c;
    logic        store_done;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    tile_t a_seq = '{32'd1, 32'd2, 32'd3, 32'd4};
    tile_t b_seq = '{32'd5, 32'd6, 32'd7, 32'd8};
    tile_t c_seq = '{32'd19, 32'd22, 32'd43, 32'd50};
    tile_t all_f = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tile_t all_2 = '{32'd2, 32'd2, 32'd2, 32'd2};
    tile_t all_8 = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    tile_t all_0 = '{32'd0, 32'd0, 32'd0, 32'd0};
    tile_t ident = '{32'd1, 32'd0, 32'd0, 32'd1};
    tile_t b_rev = '{32'd9, 32'd8, 32'd7, 32'd6};

    tcu_tile_engine #(.TILE_N(2), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .data_in_a    (data_in_a),
        .data_in_b    (data_in_b),
        .load_done    (load_done),
        .execute_done (execute_done),
        .store_start  (store_start),
        .out_valid    (out_valid),
        .data_out_c   (data_out_c),
        .store_done   (store_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        vecs++;
        if ({load_done, execute_done, out_valid, store_done, busy} !== 5'b0
            || data_out_c !== 32'd0) begin
            errs++;
            $display("FAIL %s: ld=%b ex=%b ov=%b sd=%b busy=%b c=%h, want all 0",
                     tag, load_done, execute_done, out_valid, store_done,
                     busy, data_out_c);
        end
    endtask

    task automatic do_load(input tile_t a, input tile_t b, input int st0,
                           input int st1, input bit ss_pulse,
                           input int exp_cyc);
        int cnt;
        int p;
        cnt = 0;
        p = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        while (!load_done && cnt < 40) begin
            if (p < 4 && cnt != st0 && cnt != st1) begin
                in_valid = 1'b1;
                data_in_a = a[p];
                data_in_b = b[p];
                p++;
            end else begin
                in_valid = 1'b0;
            end
            store_start = ss_pulse && (cnt == 1);
            step();
            cnt++;
            vecs++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                errs++;
                $display("FAIL load_phase: ov=%b busy=%b, want ov=0 busy=1",
                         out_valid, busy);
            end
        end
        in_valid = 1'b0;
        store_start = 1'b0;
        vecs++;
        if (cnt !== exp_cyc) begin
            errs++;
            $display("FAIL load_latency: %0d cycles, want %0d", cnt, exp_cyc);
        end
    endtask

    task automatic do_exec(input bit ls_pulse);
        int cnt;
        cnt = 0;
        while (!execute_done && cnt < 40) begin
            load_start = ls_pulse && (cnt == 3);
            step();
            cnt++;
            if (cnt == 1) begin
                vecs++;
                if (load_done !== 1'b0) begin
                    errs++;
                    $display("FAIL load_done_pulse: got %b, want 0", load_done);
                end
            end
        end
        load_start = 1'b0;
        vecs++;
        if (cnt !== 8) begin
            errs++;
            $display("FAIL exec_latency: %0d cycles, want 8", cnt);
        end
        load_start = ls_pulse;
        step();
        load_start = 1'b0;
        vecs++;
        if (execute_done !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL wait_hold: ex=%b busy=%b ov=%b, want 0 1 0",
                     execute_done, busy, out_valid);
        end
    endtask

    task automatic do_store(input tile_t c, input string tag);
        store_start = 1'b1;
        step();
        store_start = 1'b0;
        for (int m = 0; m < 4; m++) begin
            vecs++;
            if (out_valid !== 1'b1 || data_out_c !== c[m]
                || store_done !== (m == 3)) begin
                errs++;
                $display("FAIL %s beat%0d: ov=%b c=%h sd=%b, want 1 %h %b",
                         tag, m, out_valid, data_out_c, store_done, c[m],
                         m == 3);
            end
            step();
        end
        vecs++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || store_done !== 1'b0) begin
            errs++;
            $display("FAIL %s end: ov=%b busy=%b sd=%b, want 0 0 0",
                     tag, out_valid, busy, store_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        check_idle_outputs("reset_state");
        reset = 1'b1;
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        do_load(a_seq, b_seq, -1, -1, 1'b0, 4);
        do_exec(1'b0);
        do_store(c_seq, "basic");
    endtask

    task automatic test_stall();
        do_load(a_seq, b_seq, 1, 2, 1'b0, 6);
        do_exec(1'b0);
        do_store(c_seq, "stall");
    endtask

    task automatic test_wrap();
        do_load(all_f, all_f, -1, -1, 1'b0, 4);
        do_exec(1'b0);
        do_store(all_2, "wrap_ff");
        do_load(all_8, all_2, -1, -1, 1'b0, 4);
        do_exec(1'b0);
        do_store(all_0, "wrap_80");
    endtask

    task automatic test_ignored();
        do_load(a_seq, b_seq, -1, -1, 1'b1, 4);
        do_exec(1'b1);
        do_store(c_seq, "ignored");
    endtask

    task automatic test_mid_reset();
        do_load(a_seq, b_seq, -1, -1, 1'b0, 4);
        for (int n = 0; n < 4; n++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_idle_outputs("mid_reset");
        step();
        check_idle_outputs("mid_reset_idle");
        do_load(ident, b_rev, -1, -1, 1'b0, 4);
        do_exec(1'b0);
        do_store(b_rev, "post_reset");
    endtask

    task automatic test_back_to_back();
        do_load(a_seq, b_seq, -1, -1, 1'b0, 4);
        do_exec(1'b0);
        do_store(c_seq, "b2b_first");
        do_load(ident, b_rev, -1, -1, 1'b0, 4);
        do_exec(1'b0);
        do_store(b_rev, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
